// File: rtl/oled_spi_rx.sv
// SPI slave for an SSD1306-style OLED controller: deserialises bytes from the
// host and decodes column/page window commands into frame-buffer writes.
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       OLED_SCLK,
    input  logic       OLED_CS,
    input  logic       OLED_DC,
    input  logic       OLED_DIN,
    output logic [7:0] RX_BYTE,
    output logic       RX_DC,
    output logic       RX_VALID,
    output logic       FB_WE,
    output logic [9:0] FB_ADDR,
    output logic [7:0] FB_DATA,
    output logic       DISP_ON,
    output logic       FRAME_ERR
);

    typedef enum logic [2:0] {
        IDLE, COL_S, COL_E, PAGE_S, PAGE_E, SKIP
    } dec_state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, dc_sync, din_sync;
    logic                   sclk_s, cs_s, dc_s, din_s;
    logic                   sclk_d, cs_d, sclk_rise;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg, byte_next;

    dec_state_t state, state_next;
    logic [6:0] col_start, col_end, col;
    logic [2:0] page_start, page_end, page;

    // NOTE: the CS synchronizer resets to 1 so the link comes up deselected;
    // a 0 would look like a spurious CS assertion right after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
            din_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], OLED_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], OLED_CS};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], OLED_DC};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], OLED_DIN};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign byte_next = {shift_reg[6:0], din_s};

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            RX_BYTE   <= '0;
            RX_DC     <= 1'b0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            if (cs_s) begin
                bit_cnt <= '0;
                if (!cs_d && bit_cnt != 3'd0)
                    FRAME_ERR <= 1'b1;
            end else if (sclk_rise) begin
                shift_reg <= byte_next;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    RX_BYTE  <= byte_next;
                    RX_DC    <= dc_s;
                    RX_VALID <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (RX_VALID) begin
            if (RX_DC) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        case (RX_BYTE)
                            8'h21: state_next = COL_S;
                            8'h22: state_next = PAGE_S;
                            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                            8'hD5, 8'hD9, 8'hDA, 8'hDB: state_next = SKIP;
                            default: state_next = IDLE;
                        endcase
                    end
                    COL_S:   state_next = COL_E;
                    PAGE_S:  state_next = PAGE_E;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_start  <= 7'd0;
            col_end    <= 7'd127;
            page_start <= 3'd0;
            page_end   <= 3'd7;
            col        <= 7'd0;
            page       <= 3'd0;
            DISP_ON    <= 1'b0;
            FB_WE      <= 1'b0;
            FB_ADDR    <= '0;
            FB_DATA    <= '0;
        end else begin
            FB_WE <= 1'b0;
            if (RX_VALID && RX_DC) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= {page, col};
                FB_DATA <= RX_BYTE;
                // Horizontal addressing: wrap the column inside the window, then the page.
                if (col == col_end) begin
                    col  <= col_start;
                    page <= (page == page_end) ? page_start : page + 3'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end else if (RX_VALID) begin
                case (state)
                    IDLE: begin
                        if (RX_BYTE == 8'hAE) DISP_ON <= 1'b0;
                        if (RX_BYTE == 8'hAF) DISP_ON <= 1'b1;
                    end
                    COL_S:  col_start <= RX_BYTE[6:0];
                    COL_E: begin
                        col_end <= RX_BYTE[6:0];
                        col     <= col_start;
                    end
                    PAGE_S: page_start <= RX_BYTE[2:0];
                    PAGE_E: begin
                        page_end <= RX_BYTE[2:0];
                        page     <= page_start;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each SPI input (minimum 2).
REQ-002 SHALL have port CLK, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have port OLED_SCLK, input, 1, SPI clock from the master; asynchronous to CLK.
REQ-005 SHALL have port OLED_CS, input, 1, chip select, active-low.
REQ-006 SHALL have port OLED_DC, input, 1, data/command select; 0 = command, 1 = display data.
REQ-007 SHALL have port OLED_DIN, input, 1, serial data, MSB first.
REQ-008 SHALL have port RX_BYTE, output, 8, the last received byte.
REQ-009 SHALL have port RX_DC, output, 1, the OLED_DC value captured with RX_BYTE.
REQ-010 SHALL have port RX_VALID, output, 1, a one-cycle strobe marking RX_BYTE/RX_DC valid.
REQ-011 SHALL have port FB_WE, output, 1, the frame-buffer write strobe.
REQ-012 SHALL have port FB_ADDR, output, 10, the frame-buffer address, page*128+column.
REQ-013 SHALL have port FB_DATA, output, 8, the frame-buffer write data.
REQ-014 SHALL have port DISP_ON, output, 1, display-on state.
REQ-015 SHALL have port FRAME_ERR, output, 1, a one-cycle strobe marking a byte aborted by CS.

Function
REQ-016 SHALL pass OLED_SCLK, OLED_CS, OLED_DC and OLED_DIN through SYNC_STAGES flops before use; SCLK high and low times are each at least 2 CLK periods.
REQ-017 SHALL detect SCLK rising edges on the synchronized signal and shift DIN in MSB first on each rising edge while synchronized CS=0.
REQ-018 SHALL, on the 8th bit, latch RX_BYTE and RX_DC (DC sampled on that same edge), pulse RX_VALID on the next CLK, and clear the bit counter.
REQ-019 SHALL discard a partial byte when CS rises with the bit count in 1..7, pulse FRAME_ERR once and clear the bit counter; CS rising at count 0 is silent.
REQ-020 SHALL clear the bit counter without an error while CS is high, and ignore SCLK edges while CS is high.
REQ-021 SHALL run a decoder FSM with states IDLE, COL_S, COL_E, PAGE_S, PAGE_E and SKIP, advancing only on RX_VALID.
REQ-022 SHALL, in IDLE with a command byte: 0x21 -> COL_S; 0x22 -> PAGE_S; 0xAE clears DISP_ON; 0xAF sets DISP_ON; 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA and 0xDB -> SKIP; any other command is ignored (remain in IDLE).
REQ-023 SHALL, in COL_S/COL_E, load col_start/col_end from byte[6:0] and go COL_E/IDLE; on COL_E exit, set col to col_start.
REQ-024 SHALL, in PAGE_S/PAGE_E, load page_start/page_end from byte[2:0] and go PAGE_E/IDLE; on PAGE_E exit, set page to page_start.
REQ-025 SHALL, in SKIP, discard one command byte and return to IDLE.
REQ-026 SHALL, on a data byte (RX_DC=1) in any state, first force the FSM to IDLE (abandoning the pending argument, with registers already loaded retained) and then perform the write.
REQ-027 SHALL perform a write as FB_WE=1, FB_ADDR={page,col}, FB_DATA=byte for one cycle, the cycle after RX_VALID.
REQ-028 SHALL update the pointer after each write (horizontal mode): if col==col_end, col<=col_start and page advances (page_end wraps to page_start); otherwise col<=col+1 (7-bit, 127 wraps to 0).
REQ-029 SHALL leave behaviour unspecified when start>end, except that it stays bounded by the 7-bit and 3-bit wrap rules.

Reset
REQ-030 SHALL, while RST_N=0, force all outputs to 0 and clear the synchronizers (CS synchronizer to 1), the shift register and the bit counter.
REQ-031 SHALL, on reset, set the FSM to IDLE, col_start=0, col_end=127, page_start=0, page_end=7, col=0, page=0.
REQ-032 SHALL, on reset asserted mid-byte or mid-command, discard that byte or command with no RX_VALID, FB_WE or FRAME_ERR emitted.

Verification
REQ-033 SHALL cover: CS low, command 0xAF -> RX_VALID once, RX_BYTE=0xAF, RX_DC=0, DISP_ON=1, FB_WE never asserted.
REQ-034 SHALL cover: 0x21,0x02,0x03,0x22,0x05,0x05 then data 0x11,0x22,0x33 -> writes at addresses 642, 643, then 642 again (page 5 wraps to 5).
REQ-035 SHALL cover: after reset, 1025 data bytes -> addresses 0..1023 then 0; byte 1025 goes to address 0.
REQ-036 SHALL cover: 5 bits clocked then CS high -> FRAME_ERR single pulse, no RX_VALID; the next full byte 0xA5 is received correctly.
REQ-037 SHALL cover: 0x81 then data 0x7E -> FSM abandons SKIP, writes 0x7E at the current pointer; 0x81,0xAE -> 0xAE swallowed, DISP_ON unchanged.
REQ-038 SHALL cover: RST_N pulsed low after 4 bits of a data byte -> all outputs 0, pointer at 0, no write emitted.
